// File: rtl/operand_fetch_pkg.sv
// Shared types for the operand fetch stage.
//   opfetch_lw_t  : last-write record {valid, addr, data} captured on accept
//   opfetch_uop_t : opaque decoded-control payload
package operand_fetch_pkg;

  localparam int OPF_ADDR_WIDTH = 5;
  localparam int OPF_DATA_WIDTH = 64;
  localparam int OPF_UOP_WIDTH  = 32;

  typedef struct packed {
    logic                      valid;
    logic [OPF_ADDR_WIDTH-1:0] addr;
    logic [OPF_DATA_WIDTH-1:0] data;
  } opfetch_lw_t;

  typedef logic [OPF_UOP_WIDTH-1:0] opfetch_uop_t;

endpackage

// File: rtl/operand_bypass.sv
// Per-operand data path of the operand fetch stage.
// Selects the operand value for the held uop: on the first (fresh) cycle the
// register file read data, overridden by the write that landed on the accept
// edge; on later cycles a hold register that keeps absorbing writebacks.
// Register x0 always reads as zero and is never forwarded.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   valid        a uop is held (out_valid)
//   fresh        first cycle after accept
//   rs           held source register index
//   lw           write seen on the accept edge
//   rf_rdata     register file read data (1-cycle latency)
//   wb_*         writeback port
//   data         operand value
module operand_bypass
  import operand_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = OPF_ADDR_WIDTH,
  parameter int DATA_WIDTH = OPF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid,
  input  logic                  fresh,
  input  logic [ADDR_WIDTH-1:0] rs,
  input  opfetch_lw_t           lw,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  input  logic                  wb_wen,
  input  logic [ADDR_WIDTH-1:0] wb_waddr,
  input  logic [DATA_WIDTH-1:0] wb_wdata,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] held_data;
  logic                  rs_nonzero;
  logic                  lw_hit;
  logic                  wb_hit;

  assign rs_nonzero = (rs != '0);
  // The array read issued on the accept edge misses a write on that same edge.
  assign lw_hit = lw.valid && (lw.addr == rs) && rs_nonzero;
  assign wb_hit = wb_wen && (wb_waddr == rs) && rs_nonzero;

  always_comb begin
    data = held_data;
    if (!rs_nonzero) begin
      data = '0;
    end else if (fresh) begin
      data = lw_hit ? lw.data : rf_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_data <= '0;
    end else if (valid) begin
      held_data <= wb_hit ? wb_wdata : data;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Register-read stage between decode and execute.
// Accepts a decoded uop over valid/ready, drives register file read
// addresses, collects the 1-cycle-latency read data, forwards writebacks the
// array read missed and holds uop plus operands until execute accepts.
// Optional build macro OPERAND_FETCH_PERF_EN adds a 32-bit saturating
// stall_cnt output (cycles with out_valid && !out_ready, cleared by flush).
// Ports:
//   clk, rst_n              clock, async active-low reset
//   flush                   kill held uop, block accept
//   in_valid/in_ready       decode handshake; in_rs1, in_rs2, in_uop
//   rf_raddr1/2, rf_rdata1/2 register file read ports
//   wb_wen/wb_waddr/wb_wdata writeback port
//   out_valid/out_ready     execute handshake; out_rs1_data, out_rs2_data, out_uop
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = OPF_ADDR_WIDTH,
  parameter int DATA_WIDTH = OPF_DATA_WIDTH,
  parameter int UOP_WIDTH  = OPF_UOP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rs1,
  input  logic [ADDR_WIDTH-1:0] in_rs2,
  input  logic [UOP_WIDTH-1:0]  in_uop,
  output logic [ADDR_WIDTH-1:0] rf_raddr1,
  output logic [ADDR_WIDTH-1:0] rf_raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2,
  input  logic                  wb_wen,
  input  logic [ADDR_WIDTH-1:0] wb_waddr,
  input  logic [DATA_WIDTH-1:0] wb_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rs1_data,
  output logic [DATA_WIDTH-1:0] out_rs2_data,
  output logic [UOP_WIDTH-1:0]  out_uop
`ifdef OPERAND_FETCH_PERF_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  logic                  accept;
  logic                  fresh;
  logic [ADDR_WIDTH-1:0] rs1_q;
  logic [ADDR_WIDTH-1:0] rs2_q;
  opfetch_uop_t          uop_q;
  opfetch_lw_t           lw_q;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Keep reading the held registers while stalled.
  assign rf_raddr1 = accept ? in_rs1 : rs1_q;
  assign rf_raddr2 = accept ? in_rs2 : rs2_q;

  assign out_uop = uop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      fresh     <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      uop_q     <= '0;
      lw_q      <= '0;
    end else begin
      fresh <= 1'b0;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        fresh     <= 1'b1;
        rs1_q     <= in_rs1;
        rs2_q     <= in_rs2;
        uop_q     <= in_uop;
        lw_q      <= '{valid: wb_wen, addr: wb_waddr, data: wb_wdata};
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  operand_bypass #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bypass_rs1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (out_valid),
    .fresh    (fresh),
    .rs       (rs1_q),
    .lw       (lw_q),
    .rf_rdata (rf_rdata1),
    .wb_wen   (wb_wen),
    .wb_waddr (wb_waddr),
    .wb_wdata (wb_wdata),
    .data     (out_rs1_data)
  );

  operand_bypass #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bypass_rs2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (out_valid),
    .fresh    (fresh),
    .rs       (rs2_q),
    .lw       (lw_q),
    .rf_rdata (rf_rdata2),
    .wb_wen   (wb_wen),
    .wb_waddr (wb_waddr),
    .wb_wdata (wb_wdata),
    .data     (out_rs2_data)
  );

`ifdef OPERAND_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (flush) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register file
// (1-cycle registered read returning the pre-write array state).
module tb_operand_fetch;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_uop;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [63:0] rf_rdata1;
  logic [63:0] rf_rdata2;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [63:0] wb_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_rs1_data;
  logic [63:0] out_rs2_data;
  logic [31:0] out_uop;
`ifdef OPERAND_FETCH_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [63:0] rf [32];

  operand_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_uop       (in_uop),
    .rf_raddr1    (rf_raddr1),
    .rf_raddr2    (rf_raddr2),
    .rf_rdata1    (rf_rdata1),
    .rf_rdata2    (rf_rdata2),
    .wb_wen       (wb_wen),
    .wb_waddr     (wb_waddr),
    .wb_wdata     (wb_wdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rs1_data (out_rs1_data),
    .out_rs2_data (out_rs2_data),
    .out_uop      (out_uop)
`ifdef OPERAND_FETCH_PERF_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model; x0 is writable here so the DUT's x0 rule is exercised.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= 64'hDEAD_0000 + 64'(i);
      rf_rdata1 <= '0;
      rf_rdata2 <= '0;
    end else begin
      rf_rdata1 <= rf[rf_raddr1];
      rf_rdata2 <= rf[rf_raddr2];
      if (wb_wen) rf[wb_waddr] <= wb_wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] u, input logic ordy, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [63:0] wd);
    @(negedge clk);
    in_valid  = v;
    in_rs1    = r1;
    in_rs2    = r2;
    in_uop    = u;
    out_ready = ordy;
    flush     = fl;
    wb_wen    = we;
    wb_waddr  = wa;
    wb_wdata  = wd;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_uop = '0;
    out_ready = 1'b0; wb_wen = 1'b0; wb_waddr = '0; wb_wdata = '0;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_raddr1",    64'(rf_raddr1), 64'd0);
    check("rst_raddr2",    64'(rf_raddr2), 64'd0);
    check("rst_uop",       64'(out_uop),   64'd0);
`ifdef OPERAND_FETCH_PERF_EN
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    #6 rst_n = 1'b1;

    // Basic read: x5 = 0x11 written, then issued.
    drive(0, 0, 0, 0,        1, 0, 1, 5, 64'h11);
    drive(1, 5, 0, 32'h1001, 1, 0, 0, 0, 0);
    check("basic_in_ready", 64'(in_ready),  64'd1);
    check("basic_raddr1",   64'(rf_raddr1), 64'd5);
    drive(0, 0, 0, 0,        1, 0, 0, 0, 0);
    check("basic_valid", 64'(out_valid), 64'd1);
    check("basic_rs1",   out_rs1_data,   64'h11);
    check("basic_rs2",   out_rs2_data,   64'h0);
    check("basic_uop",   64'(out_uop),   64'h1001);

    // Write to x7 on the accept edge must beat the stale array read.
    drive(1, 7, 5, 32'h2002, 1, 0, 1, 7, 64'hAA);
    check("lw_prev_done", 64'(out_valid), 64'd0);
    drive(0, 0, 0, 0,        1, 0, 0, 0, 0);
    check("lw_rs1", out_rs1_data, 64'hAA);
    check("lw_rs2", out_rs2_data, 64'h11);

    // Stall for three cycles with a write to rs2=x3 landing mid-stall.
    drive(1, 5, 3, 32'h3003, 0, 0, 0, 0, 0);
    drive(1, 9, 9, 32'h9999, 0, 0, 1, 3, 64'h55);
    check("stall0_in_ready", 64'(in_ready), 64'd0);
    check("stall0_rs2",      out_rs2_data,  64'hDEAD_0003);
    drive(1, 9, 9, 32'h9999, 0, 0, 0, 0, 0);
    check("stall1_in_ready", 64'(in_ready), 64'd0);
    check("stall1_rs2",      out_rs2_data,  64'h55);
    check("stall1_rs1",      out_rs1_data,  64'h11);
    drive(1, 9, 9, 32'h9999, 0, 0, 0, 0, 0);
    check("stall2_in_ready", 64'(in_ready), 64'd0);
    check("stall2_rs2",      out_rs2_data,  64'h55);
    check("stall2_uop",      64'(out_uop),  64'h3003);

    // Flush while stalled, with a uop offered.
    drive(1, 9, 9, 32'h9999, 0, 1, 0, 0, 0);
    check("flush_in_ready", 64'(in_ready),  64'd0);
    check("flush_valid",    64'(out_valid), 64'd1);
`ifdef OPERAND_FETCH_PERF_EN
    check("flush_stall_cnt_pre", 64'(stall_cnt), 64'd3);
`endif
    drive(0, 0, 0, 0,        0, 0, 0, 0, 0);
    check("flush_valid_after", 64'(out_valid), 64'd0);
    check("flush_no_accept",   64'(rf_raddr1), 64'd5);
`ifdef OPERAND_FETCH_PERF_EN
    check("flush_stall_cnt_post", 64'(stall_cnt), 64'd0);
`endif

    // x0 is never forwarded, fresh or held.
    drive(1, 0, 0, 32'h4004, 0, 0, 1, 0, 64'hFF);
    drive(0, 0, 0, 0,        0, 0, 1, 0, 64'hFF);
    check("x0_fresh_rs1", out_rs1_data, 64'h0);
    check("x0_fresh_rs2", out_rs2_data, 64'h0);
    drive(0, 0, 0, 0,        1, 0, 0, 0, 0);
    check("x0_held_rs1", out_rs1_data,   64'h0);
    check("x0_held_valid", 64'(out_valid), 64'd1);

    // Back-to-back A, B, C; C reads x3 on both ports.
    drive(1, 5, 7, 32'hA, 1, 0, 0, 0, 0);
    check("b2b_idle", 64'(out_valid), 64'd0);
    drive(1, 3, 5, 32'hB, 1, 0, 0, 0, 0);
    check("b2b_a_valid", 64'(out_valid), 64'd1);
    check("b2b_a_ready", 64'(in_ready),  64'd1);
    check("b2b_a_uop",   64'(out_uop),   64'hA);
    check("b2b_a_rs1",   out_rs1_data,   64'h11);
    check("b2b_a_rs2",   out_rs2_data,   64'hAA);
    drive(1, 3, 3, 32'hC, 1, 0, 0, 0, 0);
    check("b2b_b_valid", 64'(out_valid), 64'd1);
    check("b2b_b_uop",   64'(out_uop),   64'hB);
    check("b2b_b_rs1",   out_rs1_data,   64'h55);
    check("b2b_b_rs2",   out_rs2_data,   64'h11);
    drive(0, 0, 0, 0,     1, 0, 0, 0, 0);
    check("b2b_c_valid", 64'(out_valid), 64'd1);
    check("b2b_c_uop",   64'(out_uop),   64'hC);
    check("b2b_c_rs1",   out_rs1_data,   64'h55);
    check("b2b_c_rs2",   out_rs2_data,   64'h55);
    drive(0, 0, 0, 0,     1, 0, 0, 0, 0);
    check("b2b_drained", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Register-read stage between decode and execute.
- Accepts one decoded uop per cycle over a valid/ready handshake and drives the register file read addresses.
- Collects the read data after the register file's fixed 1-cycle synchronous read latency.
- Forwards writeback results that the array read missed, then holds the uop and its operands until execute accepts them.

Parameters:
- ADDR_WIDTH, 5 (core_cfg.REG_ADDR_WIDTH): register index width.
- DATA_WIDTH, 64 (core_cfg.XLEN): operand/data width.
- UOP_WIDTH, 32: opaque decoded-control payload width, passed through unmodified.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill held uop; no accept this cycle
- in_valid  in  1  decode offers a uop
- in_ready  out  1  stage can accept
- in_rs1  in  ADDR_WIDTH  source register 1 index
- in_rs2  in  ADDR_WIDTH  source register 2 index
- in_uop  in  UOP_WIDTH  payload
- rf_raddr1  out  ADDR_WIDTH  to register file read port 1
- rf_raddr2  out  ADDR_WIDTH  to register file read port 2
- rf_rdata1  in  DATA_WIDTH  from register file; 1-cycle latency
- rf_rdata2  in  DATA_WIDTH  from register file; 1-cycle latency
- wb_wen  in  1  writeback enable; same signal drives the register file write
- wb_waddr  in  ADDR_WIDTH  writeback register index
- wb_wdata  in  DATA_WIDTH  writeback data
- out_valid  out  1  uop with operands available
- out_ready  in  1  execute accepts
- out_rs1_data  out  DATA_WIDTH  operand 1
- out_rs2_data  out  DATA_WIDTH  operand 2
- out_uop  out  UOP_WIDTH  payload

Behaviour:
- Reset (async, rst_n=0): out_valid=0, fresh=0, held rs1/rs2=0, held data=0, out_uop=0, last-write valid=0. rf_raddr1/2 read 0 out of reset.
- in_ready = !flush && (!out_valid || out_ready); purely combinational, no skid buffer.
- Accept = in_valid && in_ready. Throughput is 1 uop/cycle; issue-to-out_valid latency is 1 cycle.
- rf_raddrN = accept ? in_rsN : held rsN. Addresses are re-driven while stalled, so the array keeps being read for the held uop.
- On accept edge:
  - latch rs1, rs2 and uop;
  - out_valid<=1, fresh<=1;
  - capture last-write register <= {wb_wen, wb_waddr, wb_wdata}.
- Otherwise, fresh<=0 at every edge.
- The register file's registered read returns the array state from before any write at the same edge. Therefore:
  - Fresh cycle: out_rsN_data = (lw_valid && lw_addr==rsN && rsN!=0) ? lw_data : rf_rdataN. This path is combinational from rf_rdataN.
  - Held cycles: out_rsN_data = held dataN.
  - Every edge while out_valid: held dataN <= (wb_wen && wb_waddr==rsN && rsN!=0) ? wb_wdata : current out_rsN_data. This captures writes that land during a stall.
- rsN==0 always yields 0 and is never forwarded.
- Out handshake: out_valid && out_ready at edge completes the transfer. out_valid<=0 unless an accept happens in the same cycle (back-to-back). rs1==rs2 is legal; both operands get identical data.
- flush: out_valid<=0, fresh<=0, no accept. Flush has priority over out_ready and in_valid. A simultaneous wb write is still absorbed by the register file normally.
- Reset mid-operation drops the held uop; no partial output is allowed.

Optional Feature:
- OPERAND_FETCH_PERF_EN defined:
  - adds output stall_cnt (32 bits, reset 0);
  - increments by 1 each cycle with out_valid && !out_ready, saturating at all-ones;
  - cleared by flush.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared core package: opfetch_lw_t struct {valid, addr, data} and the opfetch_uop_t payload type sized by UOP_WIDTH.
- Sub-module operand_bypass, instantiated once per source operand. It contains the fresh/held mux, last-write compare, wb-capture hold register and x0 rule.
- The top level owns the handshake, address mux and payload register.

Test Plan:
- Write x5=0x11 into the array; issue rs1=5, rs2=0, out_ready=1 -> next cycle out_valid=1, rs1_data=0x11, rs2_data=0.
- Accept rs1=7 in the same cycle as wb x7=0xAA -> fresh-cycle rs1_data=0xAA (last-write forward, not the stale array value).
- Hold out_ready=0 for 3 cycles; wb x3=0x55 during the stall with rs2=3 -> rs2_data changes to 0x55 on the next cycle and stays stable; in_ready=0 throughout.
- wb x0=0xFF with rs1=0 -> rs1_data=0 in both fresh and held cycles.
- Back-to-back uops A,B,C with out_ready=1 -> out_valid high 3 consecutive cycles, in order, no bubbles.
- Assert flush during a stall -> out_valid=0 next cycle and the uop is not accepted that cycle. With OPERAND_FETCH_PERF_EN, stall_cnt reads 3 before the flush and 0 after it.
